seven_segment_display_capture: RTL



---
 rtl/seven_segment_display_capture_pkg.sv | 50 +++++
 rtl/seven_segment_display_capture_anode_decode.sv | 35 +++
 rtl/seven_segment_display_capture.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_display_capture_pkg.sv
// Shared display definitions for the seven-segment refresh path.
//   - anode_class_t   : classification of one sampled anode pattern
//   - capture_state_t : frame-capture FSM state encoding
//   - BCD_MAX         : largest legal BCD digit value
//   - decode_anodes() : one-cold anode pattern -> digit index / class.
//                       Also used by the refresh driver bench.
package seven_segment_display_capture_pkg;

    localparam int unsigned MAX_SEGMENTS = 8;
    localparam logic [3:0]  BCD_MAX      = 4'd9;

    typedef enum logic [1:0] {
        ANODE_BLANK   = 2'd0,
        ANODE_DIGIT   = 2'd1,
        ANODE_ILLEGAL = 2'd2
    } anode_class_t;

    typedef enum logic {
        ST_SEARCH  = 1'b0,
        ST_CAPTURE = 1'b1
    } capture_state_t;

    typedef struct packed {
        anode_class_t cls;
        logic [2:0]   idx;
    } anode_decode_t;

    // Unused upper anodes must be driven high (inactive) by the caller.
    function automatic anode_decode_t decode_anodes(input logic [MAX_SEGMENTS-1:0] anodes);
        anode_decode_t res;
        int unsigned   zeros;
        res.cls = ANODE_BLANK;
        res.idx = 3'd0;
        zeros   = 0;
        for (int k = 0; k < MAX_SEGMENTS; k++) begin
            if (!anodes[k]) begin
                zeros++;
                res.idx = 3'(k);
            end
        end
        if (zeros == 1) begin
            res.cls = ANODE_DIGIT;
        end else if (zeros > 1) begin
            res.cls = ANODE_ILLEGAL;
            res.idx = 3'd0;
        end
        return res;
    endfunction

endpackage

// File: rtl/seven_segment_display_capture_anode_decode.sv
// display_anode_decode: combinational decoder for the active-low anode bus.
//   anodes     in  : active-low digit enables, SEGMENT_NUM wide
//   is_digit   out : exactly one anode is low
//   is_illegal out : two or more anodes are low
//   digit_idx  out : index of the low anode (valid when is_digit)
module display_anode_decode
    import seven_segment_display_capture_pkg::*;
#(
    parameter int unsigned SEGMENT_NUM = 4,
    parameter int unsigned IDX_W       = 2
) (
    input  logic [SEGMENT_NUM-1:0] anodes,
    output logic                   is_digit,
    output logic                   is_illegal,
    output logic [IDX_W-1:0]       digit_idx
);

    logic [MAX_SEGMENTS-1:0] padded;
    anode_decode_t           dec;
    logic                    unused_idx_bits;

    always_comb begin
        padded                  = '1;
        padded[SEGMENT_NUM-1:0] = anodes;
    end

    assign dec        = decode_anodes(padded);
    assign is_digit   = (dec.cls == ANODE_DIGIT);
    assign is_illegal = (dec.cls == ANODE_ILLEGAL);
    assign digit_idx  = dec.idx[IDX_W-1:0];

    // Padding keeps the index below SEGMENT_NUM, so upper bits are always zero.
    assign unused_idx_bits = ^dec.idx;

endmodule

// File: rtl/seven_segment_display_capture.sv
// seven_segment_display_capture: rebuilds the packed BCD word from a
// time-multiplexed seven-segment refresh (digit value + active-low anodes).
//   i_Clk          in  : system clock
//   i_Reset_n      in  : synchronous active-low reset
//   i_Sample_En    in  : one-cycle strobe after each refresh step
//   i_BCD_Num_Sel  in  : BCD value currently presented
//   i_Anodes       in  : active-low digit enables
//   o_BCD_Num      out : last complete frame, digit k at [4k+3:4k]
//   o_Frame_Valid  out : pulse when o_BCD_Num updates
//   o_Stable       out : frame repeated STABLE_FRAMES times
//   o_Error        out : pulse on protocol or digit error
//   o_Timeout      out : refresh lost
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_SEARCH  | waiting for a digit-0 sample to align on a frame start
// ST_CAPTURE | collecting digits in order; exp_q is the next index wanted
module seven_segment_display_capture
    import seven_segment_display_capture_pkg::*;
#(
    parameter int unsigned SEGMENT_NUM    = 4,
    parameter int unsigned STABLE_FRAMES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset_n,
    input  logic                     i_Sample_En,
    input  logic [3:0]               i_BCD_Num_Sel,
    input  logic [SEGMENT_NUM-1:0]   i_Anodes,
    output logic [4*SEGMENT_NUM-1:0] o_BCD_Num,
    output logic                     o_Frame_Valid,
    output logic                     o_Stable,
    output logic                     o_Error,
    output logic                     o_Timeout
);

    localparam int unsigned WORD_W = 4 * SEGMENT_NUM;
    localparam int unsigned IDX_W  = (SEGMENT_NUM > 1) ? $clog2(SEGMENT_NUM) : 1;
    localparam int unsigned TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned MC_W   = $clog2(STABLE_FRAMES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(SEGMENT_NUM - 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [MC_W-1:0]  STABLE_CNT = MC_W'(STABLE_FRAMES);

    logic             is_digit;
    logic             is_illegal;
    logic [IDX_W-1:0] digit_idx;

    capture_state_t   state_q, state_d;
    logic [IDX_W-1:0] exp_q, exp_d;
    logic [WORD_W-1:0] shadow_q, shadow_d;
    logic             bad_q, bad_d;
    logic [MC_W-1:0]  match_q, match_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [WORD_W-1:0] bcd_q, bcd_d;
    logic             valid_q, valid_d;
    logic             stable_q, stable_d;
    logic             error_q, error_d;
    logic             timeout_q, timeout_d;

    logic             sample_digit;
    logic             start_frame;
    logic             store_digit;
    logic             frame_done;
    logic             timeout_hit;

    display_anode_decode #(
        .SEGMENT_NUM (SEGMENT_NUM),
        .IDX_W       (IDX_W)
    ) u_anode_decode (
        .anodes     (i_Anodes),
        .is_digit   (is_digit),
        .is_illegal (is_illegal),
        .digit_idx  (digit_idx)
    );

    assign sample_digit = i_Sample_En & is_digit;

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        shadow_d    = shadow_q;
        bad_d       = bad_q;
        match_d     = match_q;
        tmo_d       = tmo_q;
        bcd_d       = bcd_q;
        timeout_d   = timeout_q;
        valid_d     = 1'b0;
        error_d     = 1'b0;
        start_frame = 1'b0;
        store_digit = 1'b0;
        frame_done  = 1'b0;
        timeout_hit = 1'b0;

        if (i_Sample_En) begin
            case (state_q)
                ST_SEARCH: begin
                    if (is_illegal) begin
                        error_d = 1'b1;
                    end else if (is_digit && digit_idx == '0) begin
                        start_frame = 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (is_illegal || (is_digit && digit_idx != exp_q)) begin
                        error_d = 1'b1;
                        // An out-of-order digit 0 is treated as a fresh frame start.
                        if (is_digit && digit_idx == '0) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = ST_SEARCH;
                        end
                    end else if (is_digit) begin
                        store_digit = 1'b1;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end

        if (start_frame) begin
            shadow_d      = '0;
            shadow_d[3:0] = i_BCD_Num_Sel;
            bad_d         = (i_BCD_Num_Sel > BCD_MAX);
            exp_d         = (LAST_IDX == '0) ? '0 : IDX_W'(1);
            state_d       = ST_CAPTURE;
        end

        if (store_digit) begin
            for (int k = 0; k < SEGMENT_NUM; k++) begin
                if (digit_idx == IDX_W'(k)) begin
                    shadow_d[4*k +: 4] = i_BCD_Num_Sel;
                end
            end
            bad_d = bad_q | (i_BCD_Num_Sel > BCD_MAX);
            exp_d = (exp_q == LAST_IDX) ? '0 : exp_q + IDX_W'(1);
        end

        frame_done = (start_frame || store_digit) && !error_d && (digit_idx == LAST_IDX);

        if (frame_done) begin
            if (bad_d) begin
                error_d = 1'b1;
                state_d = ST_SEARCH;
            end else begin
                valid_d = 1'b1;
                bcd_d   = shadow_d;
                exp_d   = '0;
                state_d = ST_CAPTURE;
                if (shadow_d == bcd_q) begin
                    if (match_q < STABLE_CNT) begin
                        match_d = match_q + MC_W'(1);
                    end
                end else begin
                    match_d = MC_W'(1);
                end
            end
        end

        // Counts cycles since the last lit-digit sample, holding at the terminal value.
        if (sample_digit) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            timeout_hit = 1'b1;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        if (sample_digit && digit_idx == '0) begin
            timeout_d = 1'b0;
        end

        if (timeout_hit) begin
            state_d   = ST_SEARCH;
            timeout_d = 1'b1;
            match_d   = '0;
        end

        if (error_d) begin
            match_d = '0;
        end

        stable_d = (match_d >= STABLE_CNT);
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            state_q   <= ST_SEARCH;
            exp_q     <= '0;
            shadow_q  <= '0;
            bad_q     <= 1'b0;
            match_q   <= '0;
            tmo_q     <= '0;
            bcd_q     <= '0;
            valid_q   <= 1'b0;
            stable_q  <= 1'b0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            shadow_q  <= shadow_d;
            bad_q     <= bad_d;
            match_q   <= match_d;
            tmo_q     <= tmo_d;
            bcd_q     <= bcd_d;
            valid_q   <= valid_d;
            stable_q  <= stable_d;
            error_q   <= error_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_BCD_Num     = bcd_q;
    assign o_Frame_Valid = valid_q;
    assign o_Stable      = stable_q;
    assign o_Error       = error_q;
    assign o_Timeout     = timeout_q;

endmodule
